mcdt_n: RTL

Parametrised multi-channel data transfer block, successor to the fixed 3-channel mcdt. Each of NCH input channels pushes words through a valid/ready handshake into its own FIFO. An arbiter merges the channels onto a single output stream tagged with the channel id. New versus mcdt: configurable channel count, data width and FIFO depth; runtime-selectable round-robin or fixed-priority arbitration; output backpressure via mcdt_ready_i.

---
 rtl/mcdt_n_if.sv | 29 ++
 rtl/mcdt_n.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mcdt_n_if.sv
// Channel-side and output-side signals of mcdt_n, bundled for port connection.
// slave = the transfer block itself, master = whatever drives the channels and sinks the output.
interface mcdt_n_if #(
  parameter int NCH   = 3,
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  parameter int IDW   = $clog2(NCH),
  parameter int MW    = $clog2(DEPTH) + 1
);
  logic [NCH*DW-1:0] ch_data_i;
  logic [NCH-1:0]    ch_valid_i;
  logic [NCH-1:0]    ch_ready_o;
  logic [NCH*MW-1:0] ch_margin_o;
  logic              arb_mode_i;
  logic [DW-1:0]     mcdt_data_o;
  logic              mcdt_val_o;
  logic [IDW-1:0]    mcdt_id_o;
  logic              mcdt_ready_i;

  modport slave (
    input  ch_data_i, ch_valid_i, arb_mode_i, mcdt_ready_i,
    output ch_ready_o, ch_margin_o, mcdt_data_o, mcdt_val_o, mcdt_id_o
  );

  modport master (
    output ch_data_i, ch_valid_i, arb_mode_i, mcdt_ready_i,
    input  ch_ready_o, ch_margin_o, mcdt_data_o, mcdt_val_o, mcdt_id_o
  );
endinterface

// File: rtl/mcdt_n.sv
// Multi-channel data transfer: NCH per-channel FIFOs merged onto one tagged
// output stream by a round-robin / fixed-priority arbiter with backpressure.

module mcdt_n_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  parameter int MW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic          ready_o,
  output logic [MW-1:0] margin_o,
  output logic [DW-1:0] rdata_o,
  output logic          nempty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [MW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Full/empty come from the registered count only, so a same-cycle pop
  // never frees a slot and a same-cycle push is never visible to the reader.
  assign ready_o  = (count_q != MW'(DEPTH)) && !rst_i;
  assign nempty_o = (count_q != '0);
  assign margin_o = MW'(DEPTH) - count_q;
  assign rdata_o  = mem_q[rd_ptr_q];
  assign do_push  = push_i && ready_o;
  assign do_pop   = pop_i && nempty_o;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + MW'(1);
      2'b01:   count_d = count_q - MW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

module mcdt_n #(
  parameter int NCH   = 3,
  parameter int DW    = 32,
  parameter int DEPTH = 32
) (
  input  logic   clk_i,
  input  logic   rst_i,
  mcdt_n_if.slave bus
);
  localparam int IDW = $clog2(NCH);
  localparam int MW  = $clog2(DEPTH) + 1;

  logic [NCH-1:0][DW-1:0] rdata;
  logic [NCH-1:0]         nempty;
  logic [NCH-1:0]         pop;
  logic [IDW-1:0]         grant, cand;
  logic                   load;
  int                     idx;

  logic [DW-1:0]  data_q, data_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] last_q, last_d;
  logic           val_q, val_d;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    mcdt_n_fifo #(.DW(DW), .DEPTH(DEPTH), .MW(MW)) u_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .push_i   (bus.ch_valid_i[c]),
      .wdata_i  (bus.ch_data_i[c*DW +: DW]),
      .pop_i    (pop[c]),
      .ready_o  (bus.ch_ready_o[c]),
      .margin_o (bus.ch_margin_o[c*MW +: MW]),
      .rdata_o  (rdata[c]),
      .nempty_o (nempty[c])
    );
  end

  // Both searches scan from lowest to highest priority so the last hit wins.
  // Round-robin: offset NCH is last_q itself, i.e. the previous winner goes last.
  always_comb begin
    grant = '0;
    cand  = '0;
    idx   = 0;
    if (bus.arb_mode_i) begin
      for (int i = NCH - 1; i >= 0; i--)
        if (nempty[i]) grant = IDW'(i);
    end else begin
      for (int k = NCH; k >= 1; k--) begin
        idx = int'(last_q) + k;
        if (idx >= NCH) idx = idx - NCH;
        cand = IDW'(idx);
        if (nempty[cand]) grant = cand;
      end
    end
  end

  assign load = (!val_q || bus.mcdt_ready_i) && (|nempty);
  assign pop  = load ? (NCH'(1) << grant) : '0;

  always_comb begin
    data_d = data_q;
    id_d   = id_q;
    val_d  = val_q;
    last_d = last_q;
    if (load) begin
      data_d = rdata[grant];
      id_d   = grant;
      val_d  = 1'b1;
      last_d = grant;
    end else if (bus.mcdt_ready_i) begin
      val_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      id_q   <= '0;
      val_q  <= 1'b0;
      last_q <= IDW'(NCH - 1);
    end else begin
      data_q <= data_d;
      id_q   <= id_d;
      val_q  <= val_d;
      last_q <= last_d;
    end
  end

  assign bus.mcdt_data_o = data_q;
  assign bus.mcdt_id_o   = id_q;
  assign bus.mcdt_val_o  = val_q;
endmodule
